// File: rtl/nf_sume_10g_gt_reset_sequencer_if.sv
// QPLL/GT reset controls and lock status exchanged between the reset sequencer
// and the shared-logic / PCS-PMA side.
interface nf_sume_10g_gt_reset_sequencer_if #(
    parameter int C_NUM_LANES = 4
);
    logic                   qplllock;
    logic [C_NUM_LANES-1:0] lane_enable;
    logic [C_NUM_LANES-1:0] lane_block_lock;
    logic                   qpllreset;
    logic                   gttxreset;
    logic [C_NUM_LANES-1:0] gtrxreset;
    logic                   reset_done;
    logic [2:0]             seq_state;
    logic [7:0]             retry_count;

    modport master (
        output qplllock, lane_enable, lane_block_lock,
        input  qpllreset, gttxreset, gtrxreset, reset_done, seq_state, retry_count
    );

    modport slave (
        input  qplllock, lane_enable, lane_block_lock,
        output qpllreset, gttxreset, gtrxreset, reset_done, seq_state, retry_count
    );
endinterface

// File: rtl/nf_sume_10g_gt_reset_sequencer.sv
// 10GBASE-R shared QPLL/GT reset sequencer: bring-up with lock timeout/retry, then
// round-robin per-lane RX re-reset for lanes whose PCS block lock stays lost.
module nf_sume_10g_gt_reset_sequencer #(
    parameter int C_NUM_LANES           = 4,
    parameter int C_HOLDOFF_CYCLES      = 128,
    parameter int C_QPLL_RESET_CYCLES   = 4,
    parameter int C_LOCK_TIMEOUT_CYCLES = 65536,
    parameter int C_GT_RESET_CYCLES     = 4,
    parameter int C_BLOCK_LOCK_TIMEOUT  = 1048576
) (
    input  logic                            clk156,
    input  logic                            areset_clk156,
    nf_sume_10g_gt_reset_sequencer_if.slave gt_if
);
    localparam int MAX_A   = (C_HOLDOFF_CYCLES > C_QPLL_RESET_CYCLES) ? C_HOLDOFF_CYCLES : C_QPLL_RESET_CYCLES;
    localparam int MAX_B   = (C_LOCK_TIMEOUT_CYCLES > C_GT_RESET_CYCLES) ? C_LOCK_TIMEOUT_CYCLES : C_GT_RESET_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = $clog2(C_BLOCK_LOCK_TIMEOUT + 1);
    localparam int LR_W    = $clog2(C_GT_RESET_CYCLES + 1);
    localparam int LANE_W  = (C_NUM_LANES > 1) ? $clog2(C_NUM_LANES) : 1;

    typedef enum logic [2:0] {
        ST_HOLDOFF    = 3'd0,
        ST_QPLL_RESET = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_GT_RESET   = 3'd3,
        ST_RUN        = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             retry_q, retry_d;
    logic                   lock_meta_q, lock_sync_q;

    logic                   qpllreset_q, qpllreset_d;
    logic                   gttxreset_q, gttxreset_d;
    logic [C_NUM_LANES-1:0] gtrxreset_q, gtrxreset_d;
    logic                   reset_done_q, reset_done_d;

    logic [WD_W-1:0]        wd_q [C_NUM_LANES];
    logic [WD_W-1:0]        wd_d [C_NUM_LANES];
    logic [C_NUM_LANES-1:0] req_q, req_d;
    logic                   lr_active_q, lr_active_d;
    logic [LANE_W-1:0]      lr_lane_q, lr_lane_d;
    logic [LR_W-1:0]        lr_cnt_q, lr_cnt_d;
    logic [LANE_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                   run_stay;
    logic                   lr_done;
    logic                   grant_vld;
    logic [LANE_W-1:0]      grant_lane;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [LANE_W-1:0] wrap_lane(input logic [LANE_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= C_NUM_LANES) s = s - C_NUM_LANES;
        return LANE_W'(s);
    endfunction

    // qplllock comes straight from the GT common and is asynchronous here
    always_ff @(posedge clk156) begin
        if (areset_clk156) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= gt_if.qplllock;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_ff @(posedge clk156) begin
        if (areset_clk156) begin
            state_q <= ST_HOLDOFF;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = (cnt_q < CNT_W'(CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            ST_HOLDOFF: begin
                if (cnt_q == CNT_W'(C_HOLDOFF_CYCLES - 1)) state_d = ST_QPLL_RESET;
            end
            ST_QPLL_RESET: begin
                if (cnt_q == CNT_W'(C_QPLL_RESET_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = ST_GT_RESET;
                end else if (cnt_q == CNT_W'(C_LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_QPLL_RESET;
                    retry_d = sat_inc8(retry_q);
                end
            end
            ST_GT_RESET: begin
                if (!lock_sync_q) begin
                    state_d = ST_QPLL_RESET;
                    retry_d = sat_inc8(retry_q);
                end else if (cnt_q == CNT_W'(C_GT_RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_sync_q) begin
                    state_d = ST_QPLL_RESET;
                    retry_d = sat_inc8(retry_q);
                end
            end
            default: state_d = ST_HOLDOFF;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Lane arbiter and watchdogs only advance while RUN persists, so lock loss aborts them
    always_comb begin
        run_stay    = (state_q == ST_RUN) && (state_d == ST_RUN);
        lr_done     = lr_active_q && (lr_cnt_q == LR_W'(C_GT_RESET_CYCLES - 1));
        grant_vld   = 1'b0;
        grant_lane  = '0;
        lr_active_d = lr_active_q;
        lr_lane_d   = lr_lane_q;
        lr_cnt_d    = lr_cnt_q;
        rr_ptr_d    = rr_ptr_q;

        // Descending scan leaves the nearest pending lane at or after rr_ptr as the winner
        for (int k = C_NUM_LANES - 1; k >= 0; k--) begin
            if (req_q[wrap_lane(rr_ptr_q, k)]) begin
                grant_vld  = 1'b1;
                grant_lane = wrap_lane(rr_ptr_q, k);
            end
        end

        if (!run_stay) begin
            lr_active_d = 1'b0;
            lr_cnt_d    = '0;
        end else if (lr_active_q) begin
            if (lr_done) begin
                lr_active_d = 1'b0;
                lr_cnt_d    = '0;
                rr_ptr_d    = wrap_lane(lr_lane_q, 1);
            end else begin
                lr_cnt_d = lr_cnt_q + 1'b1;
            end
        end else if (grant_vld) begin
            lr_active_d = 1'b1;
            lr_lane_d   = grant_lane;
            lr_cnt_d    = '0;
        end

        for (int i = 0; i < C_NUM_LANES; i++) begin
            if (!run_stay || !gt_if.lane_enable[i] || gt_if.lane_block_lock[i] ||
                (lr_active_q && (lr_lane_q == LANE_W'(i)))) begin
                wd_d[i] = '0;
            end else if (wd_q[i] < WD_W'(C_BLOCK_LOCK_TIMEOUT)) begin
                wd_d[i] = wd_q[i] + 1'b1;
            end else begin
                wd_d[i] = wd_q[i];
            end

            if (!run_stay || !gt_if.lane_enable[i] || (lr_done && (lr_lane_q == LANE_W'(i)))) begin
                req_d[i] = 1'b0;
            end else if (wd_d[i] == WD_W'(C_BLOCK_LOCK_TIMEOUT)) begin
                req_d[i] = 1'b1;
            end else begin
                req_d[i] = req_q[i];
            end
        end
    end

    // Outputs are registered from next-state so they line up with the state entered
    always_comb begin
        qpllreset_d  = (state_d == ST_HOLDOFF) || (state_d == ST_QPLL_RESET);
        gttxreset_d  = (state_d != ST_RUN);
        reset_done_d = (state_d == ST_RUN);
        gtrxreset_d  = '1;
        for (int i = 0; i < C_NUM_LANES; i++) begin
            gtrxreset_d[i] = (state_d != ST_RUN) || !gt_if.lane_enable[i] ||
                             (lr_active_d && (lr_lane_d == LANE_W'(i)));
        end
    end

    always_ff @(posedge clk156) begin
        if (areset_clk156) begin
            qpllreset_q  <= 1'b1;
            gttxreset_q  <= 1'b1;
            gtrxreset_q  <= '1;
            reset_done_q <= 1'b0;
            req_q        <= '0;
            lr_active_q  <= 1'b0;
            lr_lane_q    <= '0;
            lr_cnt_q     <= '0;
            rr_ptr_q     <= '0;
            for (int i = 0; i < C_NUM_LANES; i++) wd_q[i] <= '0;
        end else begin
            qpllreset_q  <= qpllreset_d;
            gttxreset_q  <= gttxreset_d;
            gtrxreset_q  <= gtrxreset_d;
            reset_done_q <= reset_done_d;
            req_q        <= req_d;
            lr_active_q  <= lr_active_d;
            lr_lane_q    <= lr_lane_d;
            lr_cnt_q     <= lr_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int i = 0; i < C_NUM_LANES; i++) wd_q[i] <= wd_d[i];
        end
    end

    assign gt_if.qpllreset   = qpllreset_q;
    assign gt_if.gttxreset   = gttxreset_q;
    assign gt_if.gtrxreset   = gtrxreset_q;
    assign gt_if.reset_done  = reset_done_q;
    assign gt_if.seq_state   = state_q;
    assign gt_if.retry_count = retry_q;

endmodule

// File: tb/tb_nf_sume_10g_gt_reset_sequencer.sv
// Directed bench for the GT reset sequencer; lane RX reset pulses are scored
// against an expected-pulse queue filled when the stimulus is applied.
`timescale 1ns/1ps
module tb_nf_sume_10g_gt_reset_sequencer;
    localparam int N  = 4;
    localparam int H  = 8;
    localparam int Q  = 4;
    localparam int T  = 32;
    localparam int G  = 4;
    localparam int TO = 16;

    logic clk156 = 1'b0;
    logic areset_clk156;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    nf_sume_10g_gt_reset_sequencer_if #(.C_NUM_LANES(N)) gt_if ();

    nf_sume_10g_gt_reset_sequencer #(
        .C_NUM_LANES(N), .C_HOLDOFF_CYCLES(H), .C_QPLL_RESET_CYCLES(Q),
        .C_LOCK_TIMEOUT_CYCLES(T), .C_GT_RESET_CYCLES(G), .C_BLOCK_LOCK_TIMEOUT(TO)
    ) u_dut (
        .clk156        (clk156),
        .areset_clk156 (areset_clk156),
        .gt_if         (gt_if.slave)
    );

    always #5 clk156 = ~clk156;
    always @(posedge clk156) cyc <= cyc + 1;

    typedef struct { int lane; int start; int width; } pulse_t;
    typedef struct { string tag; int lane; int start_lo; int start_hi; int width; } exp_t;
    pulse_t obs_q[$];
    exp_t   exp_q[$];

    function automatic pulse_t mk_pulse(input int lane, input int start, input int width);
        pulse_t p;
        p.lane = lane; p.start = start; p.width = width;
        return p;
    endfunction

    function automatic exp_t mk_exp(input string tag, input int lane, input int lo, input int hi, input int width);
        exp_t e;
        e.tag = tag; e.lane = lane; e.start_lo = lo; e.start_hi = hi; e.width = width;
        return e;
    endfunction

    // Monitor: a lane pulse is a rise then fall of gtrxreset on an enabled lane while in RUN
    logic [N-1:0] prev_rx = '1;
    logic         prev_rd = 1'b0;
    logic [N-1:0] open_m  = '0;
    int           open_start [N];
    int           overlap_cnt = 0;

    always @(negedge clk156) begin
        for (int i = 0; i < N; i++) begin
            if (!gt_if.reset_done) begin
                open_m[i] <= 1'b0;
            end else if (prev_rd && !prev_rx[i] && gt_if.gtrxreset[i] && gt_if.lane_enable[i]) begin
                open_m[i]     <= 1'b1;
                open_start[i] <= cyc;
            end else if (open_m[i] && !gt_if.gtrxreset[i]) begin
                obs_q.push_back(mk_pulse(i, open_start[i], cyc - open_start[i]));
                open_m[i] <= 1'b0;
            end
        end
        if ($countones(open_m) > 1) overlap_cnt <= overlap_cnt + 1;
        prev_rx <= gt_if.gtrxreset;
        prev_rd <= gt_if.reset_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk156);
    endtask

    task automatic sb_check(input int budget);
        exp_t   e;
        pulse_t p;
        int     waited;
        e = exp_q.pop_front();
        waited = 0;
        while (obs_q.size() == 0 && waited < budget) begin
            @(negedge clk156);
            waited++;
        end
        chk({e.tag, "_seen"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() != 0) begin
            p = obs_q.pop_front();
            chk({e.tag, "_lane"}, p.lane, e.lane);
            chk({e.tag, "_width"}, p.width, e.width);
            chk_rng({e.tag, "_start"}, p.start, e.start_lo, e.start_hi);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int r;
        int c0;

        // Reset held with live-looking inputs: reset must win
        areset_clk156 = 1'b1;
        gt_if.qplllock = 1'b1;
        gt_if.lane_enable = '1;
        gt_if.lane_block_lock = '0;
        repeat (3) @(negedge clk156);
        chk("rst_qpllreset", gt_if.qpllreset, 1);
        chk("rst_gttxreset", gt_if.gttxreset, 1);
        chk("rst_gtrxreset", gt_if.gtrxreset, 4'hF);
        chk("rst_reset_done", gt_if.reset_done, 0);
        chk("rst_seq_state", gt_if.seq_state, 0);
        chk("rst_retry", gt_if.retry_count, 0);

        // Nominal bring-up, lock from cycle 20
        gt_if.qplllock = 1'b0;
        gt_if.lane_block_lock = '1;
        areset_clk156 = 1'b0;
        r = cyc;
        wait_cyc(r + 7);  chk("nom_holdoff_end", gt_if.seq_state, 0);
        wait_cyc(r + 8);  chk("nom_qpll_entry", gt_if.seq_state, 1);
        wait_cyc(r + 11); chk("nom_qpllreset_hi", gt_if.qpllreset, 1);
        wait_cyc(r + 12); chk("nom_qpllreset_lo", gt_if.qpllreset, 0);
                          chk("nom_wait_lock", gt_if.seq_state, 2);
                          chk("nom_tx_held", gt_if.gttxreset, 1);
        wait_cyc(r + 20); gt_if.qplllock = 1'b1;
        wait_cyc(r + 22); chk("nom_sync_delay", gt_if.seq_state, 2);
        wait_cyc(r + 23); chk("nom_gt_reset", gt_if.seq_state, 3);
        wait_cyc(r + 26); chk("nom_gt_tx_held", gt_if.gttxreset, 1);
                          chk("nom_gt_rx_held", gt_if.gtrxreset, 4'hF);
        wait_cyc(r + 27); chk("nom_run", gt_if.seq_state, 4);
                          chk("nom_tx_rel", gt_if.gttxreset, 0);
                          chk("nom_rx_rel", gt_if.gtrxreset, 4'h0);
                          chk("nom_done", gt_if.reset_done, 1);
                          chk("nom_retry", gt_if.retry_count, 0);

        // Lane 2 loses block lock with the arbiter idle
        repeat (3) @(negedge clk156);
        c0 = cyc;
        gt_if.lane_block_lock[2] = 1'b0;
        exp_q.push_back(mk_exp("lane2", 2, c0 + TO + 1, c0 + TO + 1, G));
        wait_cyc(c0 + TO); chk("lane2_pre", gt_if.gtrxreset, 4'h0);
        wait_cyc(c0 + TO + 2); chk("lane2_mid", gt_if.gtrxreset, 4'h4);
        wait_cyc(c0 + 23); gt_if.lane_block_lock[2] = 1'b1;
        sb_check(20);
        chk("lane2_others_quiet", obs_q.size(), 0);

        // Lane 0 alone, wrapping from rr_ptr=3 leaves rr_ptr=1
        repeat (3) @(negedge clk156);
        c0 = cyc;
        gt_if.lane_block_lock[0] = 1'b0;
        exp_q.push_back(mk_exp("lane0", 0, c0 + TO + 1, c0 + TO + 1, G));
        wait_cyc(c0 + 23); gt_if.lane_block_lock[0] = 1'b1;
        sb_check(20);

        // Lanes 0, 1, 3 time out together: served 1, 3, 0
        repeat (3) @(negedge clk156);
        c0 = cyc;
        gt_if.lane_block_lock = 4'b0100;
        exp_q.push_back(mk_exp("rr_first", 1, c0 + TO + 1, c0 + TO + 1, G));
        exp_q.push_back(mk_exp("rr_second", 3, c0 + TO + 1 + G, c0 + TO + 2 + G, G));
        exp_q.push_back(mk_exp("rr_third", 0, c0 + TO + 1 + 2 * G, c0 + TO + 3 + 2 * G, G));
        wait_cyc(c0 + 22); gt_if.lane_block_lock = '1;
        wait_cyc(c0 + 45);
        sb_check(10);
        sb_check(10);
        sb_check(10);
        chk("rr_no_extra", obs_q.size(), 0);
        chk("rr_no_overlap", overlap_cnt, 0);

        // One-cycle lock drop in RUN forces a full re-sequence
        repeat (3) @(negedge clk156);
        c0 = cyc;
        gt_if.qplllock = 1'b0;
        @(negedge clk156);
        gt_if.qplllock = 1'b1;
        wait_cyc(c0 + 2);  chk("ll_still_run", gt_if.seq_state, 4);
        wait_cyc(c0 + 3);  chk("ll_qpll_reset", gt_if.seq_state, 1);
                           chk("ll_rx_all", gt_if.gtrxreset, 4'hF);
                           chk("ll_tx", gt_if.gttxreset, 1);
                           chk("ll_done_lo", gt_if.reset_done, 0);
                           chk("ll_retry", gt_if.retry_count, 1);
                           chk("ll_qpllreset", gt_if.qpllreset, 1);
        wait_cyc(c0 + 7);  chk("ll_wait_lock", gt_if.seq_state, 2);
        wait_cyc(c0 + 8);  chk("ll_gt_reset", gt_if.seq_state, 3);
        wait_cyc(c0 + 11); chk("ll_done_still_lo", gt_if.reset_done, 0);
        wait_cyc(c0 + 12); chk("ll_run", gt_if.seq_state, 4);
                           chk("ll_done_hi", gt_if.reset_done, 1);
                           chk("ll_rx_rel", gt_if.gtrxreset, 4'h0);

        // Lane 3 disabled; lock loss in the middle of a lane 1 pulse
        gt_if.lane_enable[3] = 1'b0;
        @(negedge clk156);
        chk("dis_lane3", gt_if.gtrxreset, 4'h8);
        c0 = cyc;
        gt_if.lane_block_lock[1] = 1'b0;
        wait_cyc(c0 + TO + 1); chk("ab_pulse_on", gt_if.gtrxreset, 4'hA);
        gt_if.qplllock = 1'b0;
        @(negedge clk156);
        gt_if.qplllock = 1'b1;
        wait_cyc(c0 + TO + 3); chk("ab_pulse_mid", gt_if.gtrxreset, 4'hA);
        wait_cyc(c0 + TO + 4); chk("ab_state", gt_if.seq_state, 1);
                               chk("ab_rx_all", gt_if.gtrxreset, 4'hF);
                               chk("ab_retry", gt_if.retry_count, 2);
                               chk("ab_done_lo", gt_if.reset_done, 0);
        gt_if.lane_block_lock[1] = 1'b1;
        wait_cyc(c0 + TO + 13); chk("ab_rerun", gt_if.seq_state, 4);
                                chk("ab_rx_rerun", gt_if.gtrxreset, 4'h8);
        wait_cyc(c0 + TO + 45); chk("ab_req_cleared", obs_q.size(), 0);
                                chk("ab_rx_quiet", gt_if.gtrxreset, 4'h8);

        // Fresh reset, lock absent for 100 cycles: two timeouts then normal bring-up
        areset_clk156 = 1'b1;
        gt_if.qplllock = 1'b0;
        gt_if.lane_enable = '1;
        gt_if.lane_block_lock = '1;
        repeat (2) @(negedge clk156);
        chk("rst2_retry", gt_if.retry_count, 0);
        chk("rst2_state", gt_if.seq_state, 0);
        areset_clk156 = 1'b0;
        r = cyc;
        wait_cyc(r + 50);  chk("to_retry1", gt_if.retry_count, 1);
                           chk("to_wait1", gt_if.seq_state, 2);
        wait_cyc(r + 90);  chk("to_retry2", gt_if.retry_count, 2);
                           chk("to_wait2", gt_if.seq_state, 2);
        wait_cyc(r + 100); gt_if.qplllock = 1'b1;
        wait_cyc(r + 102); chk("to_sync_delay", gt_if.seq_state, 2);
        wait_cyc(r + 103); chk("to_gt_reset", gt_if.seq_state, 3);
        wait_cyc(r + 107); chk("to_run", gt_if.seq_state, 4);
                           chk("to_done", gt_if.reset_done, 1);
                           chk("to_retry_final", gt_if.retry_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/nf_sume_10g_gt_reset_sequencer.md
# nf_sume_10g_gt_reset_sequencer

Bring-up and recovery controller for the shared 10GBASE-R clocking/reset logic on NetFPGA SUME. It sequences QPLL reset, waits for QPLL lock with timeout-and-retry, then releases the shared GT TX reset and per-lane GT RX resets. In RUN it re-resets individual RX lanes whose PCS block lock stays lost, one lane at a time, round-robin. It sits between the shared-logic block and the per-port PCS/PMA cores, in the clk156 domain.

## Interface
- C_NUM_LANES, 4: number of 10G lanes sharing the QPLL (1..8)
- C_HOLDOFF_CYCLES, 128: post-reset hold-off before the first QPLL reset
- C_QPLL_RESET_CYCLES, 4: qpllreset pulse width
- C_LOCK_TIMEOUT_CYCLES, 65536: WAIT_LOCK timeout
- C_GT_RESET_CYCLES, 4: GT TX/RX reset pulse width
- C_BLOCK_LOCK_TIMEOUT, 1048576: cycles of lost block lock before a lane RX reset

Ports:
- clk156  in  1  156.25 MHz clock; all logic on rising edge
- areset_clk156  in  1  synchronous, active-high reset
- qplllock  in  1  QPLL lock from GT common; asynchronous, 2-FF synchronized internally
- lane_enable  in  C_NUM_LANES  lane is in use
- lane_block_lock  in  C_NUM_LANES  PCS block lock per lane (clk156 domain)
- qpllreset  out  1  QPLL reset
- gttxreset  out  1  shared GT TX reset
- gtrxreset  out  C_NUM_LANES  per-lane GT RX reset
- reset_done  out  1  high only in RUN
- seq_state  out  3  current state encoding
- retry_count  out  8  QPLL re-reset count, saturates at 255

## Operation
- States (seq_state): HOLDOFF=0, QPLL_RESET=1, WAIT_LOCK=2, GT_RESET=3, RUN=4. One shared cycle counter, cleared on every state entry.
- HOLDOFF: qpllreset=1, gttxreset=1, gtrxreset=all 1. After C_HOLDOFF_CYCLES cycles -> QPLL_RESET.
- QPLL_RESET: qpllreset=1 for C_QPLL_RESET_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: qpllreset=0; GT resets stay 1. qplllock_sync=1 -> GT_RESET. Counter reaches C_LOCK_TIMEOUT_CYCLES first -> retry_count+1, -> QPLL_RESET.
- GT_RESET: GT resets held C_GT_RESET_CYCLES more cycles, then gttxreset=0 and gtrxreset[i]=~lane_enable[i] -> RUN. qplllock_sync=0 here -> retry_count+1, -> QPLL_RESET.
- RUN: reset_done=1. qplllock_sync=0 -> retry_count+1, -> QPLL_RESET, all GT resets to 1 and any lane reset aborted.
- Lane watchdog (RUN only): per-lane counter increments while lane_enable[i]=1 and lane_block_lock[i]=0. It clears on block lock, on disable, or on that lane's RX reset. At C_BLOCK_LOCK_TIMEOUT it raises a pending request and holds.
- Lane arbiter: one lane RX reset at a time. With none active, grant the first pending lane at or after rr_ptr (wrapping). Pulse gtrxreset[grant] for C_GT_RESET_CYCLES. Clear that request and watchdog; rr_ptr = grant+1 mod C_NUM_LANES. rr_ptr resets to 0.
- Disabled lanes: gtrxreset[i]=1 in all states. A lane disabled mid-pulse keeps gtrxreset[i]=1.
- Counters sized ceil(log2(max value+1)); no wrap.

## Timing
- Reset values: qpllreset=1, gttxreset=1, gtrxreset=all 1, reset_done=0, seq_state=0, retry_count=0, rr_ptr=0, watchdogs/requests=0.
- areset_clk156 overrides all other inputs in the same cycle.
- All outputs are registered and reflect the state entered on the same edge.
- qplllock -> qplllock_sync takes 2 cycles. The WAIT_LOCK->GT_RESET edge occurs on the cycle after qplllock_sync is first sampled 1.
- HOLDOFF lasts exactly C_HOLDOFF_CYCLES cycles; QPLL_RESET exactly C_QPLL_RESET_CYCLES; GT_RESET exactly C_GT_RESET_CYCLES.
- Lost block lock to gtrxreset rise: C_BLOCK_LOCK_TIMEOUT+1 cycles when the arbiter is idle.
- Lock loss and lane-reset completion on the same cycle: lock loss wins.

## Test plan
Sim parameters: C_HOLDOFF_CYCLES=8, C_QPLL_RESET_CYCLES=4, C_LOCK_TIMEOUT_CYCLES=32, C_GT_RESET_CYCLES=4, C_BLOCK_LOCK_TIMEOUT=16.

- Nominal bring-up: reset, then qplllock=1 from cycle 20, all lanes enabled. qpllreset falls after cycle 12; GT resets fall 4 cycles after entering GT_RESET; reset_done=1; retry_count=0.
- Lock timeout: qplllock=0 for 100 cycles, then 1. Expect 2 timeouts, retry_count=2, then normal entry to RUN.
- Lock loss in RUN: drop qplllock for 1 cycle. Expect seq_state=1 at 3 cycles later, all gtrxreset=1, reset_done=0, retry_count+1, then full re-sequence.
- Lane recovery: in RUN, hold lane_block_lock[2]=0. Expect gtrxreset[2]=1 for exactly 4 cycles, 17 cycles after the drop; other lanes unaffected.
- Round-robin: lanes 0, 1 and 3 time out on the same cycle with rr_ptr=1. Expect pulses in order 1, 3, 0, back-to-back, never overlapping.
- Disabled lane/abort: lane_enable[3]=0 keeps gtrxreset[3]=1 through RUN. Lock loss mid lane-1 pulse aborts it; the watchdog and request are cleared.
